// File: rtl/encoder_quad_decoder.sv
// Rotary encoder front end: per-pin 2-flop sync, debounce with priming, edge pulses, step/dir.
// Define ENC_FULL_QUAD_EN for 4x quadrature decode with illegal-transition err; default is 1x.
module encoder_quad_decoder #(
  parameter int DB_CYCLES = 100000,
  parameter int CNT_W     = $clog2(DB_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic enc_btn,
  output logic enc_a_db,
  output logic enc_b_db,
  output logic enc_btn_db,
  output logic enc_a_rise,
  output logic enc_btn_press,
  output logic step,
  output logic dir,
  output logic err
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(DB_CYCLES - 1);

  // Pin index: 0 = A, 1 = B, 2 = button.
  logic [2:0]       raw;
  logic [2:0]       s1, s2, db, primed, acc, live;
  logic [CNT_W-1:0] cnt  [3];
  logic [CNT_W-1:0] stab [3];

  assign raw = {enc_btn, enc_b, enc_a};

  // acc marks the edge a new level was accepted; live says it was accepted while primed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      primed <= '0;
      acc    <= '0;
      live   <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i]  <= '0;
        stab[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        acc[i]  <= 1'b0;
        live[i] <= 1'b0;
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
          if (!primed[i]) begin
            if (stab[i] == ST_LAST) primed[i] <= 1'b1;
            else                    stab[i]   <= stab[i] + 1'b1;
          end
        end else if (cnt[i] == DB_LAST) begin
          db[i]     <= s2[i];
          cnt[i]    <= '0;
          acc[i]    <= 1'b1;
          live[i]   <= primed[i];
          primed[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign enc_a_db   = db[0];
  assign enc_b_db   = db[1];
  assign enc_btn_db = db[2];

`ifdef ENC_FULL_QUAD_EN
  logic [1:0] qs, cur;
  logic       hold_off, one_bit, err_r;
  logic       unused_ok;

  assign cur       = {db[0], db[1]};
  // A change from an unprimed acceptance must not produce step or err.
  assign hold_off  = (acc[0] & ~live[0]) | (acc[1] & ~live[1]);
  assign one_bit   = acc[0] ^ acc[1];
  assign unused_ok = acc[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_a_rise    <= 1'b0;
      enc_btn_press <= 1'b0;
      step          <= 1'b0;
      dir           <= 1'b0;
      err_r         <= 1'b0;
      qs            <= 2'b00;
    end else begin
      enc_a_rise    <= live[0] & db[0];
      enc_btn_press <= live[2] & db[2];
      qs            <= cur;
      step          <= one_bit & ~hold_off;
      err_r         <= acc[0] & acc[1] & ~hold_off;
      // Up order 00->10->11->01: new A differs from previous B.
      dir           <= one_bit & ~hold_off & (cur[1] ^ qs[0]);
    end
  end

  assign err = err_r;
`else
  logic unused_ok;

  assign unused_ok = ^{acc, live[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_a_rise    <= 1'b0;
      enc_btn_press <= 1'b0;
      step          <= 1'b0;
      dir           <= 1'b0;
    end else begin
      enc_a_rise    <= live[0] & db[0];
      enc_btn_press <= live[2] & db[2];
      step          <= live[0] & db[0];
      dir           <= live[0] & db[0] & db[1];
    end
  end

  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_encoder_quad_decoder.sv
// Bench for encoder_quad_decoder: reference model predicts pulses into a queue, a monitor pops and compares.
module tb_encoder_quad_decoder;
  localparam int DB = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b0, enc_b = 1'b0, enc_btn = 1'b0;
  logic enc_a_db, enc_b_db, enc_btn_db, enc_a_rise, enc_btn_press, step, dir, err;

  encoder_quad_decoder #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn),
    .enc_a_db(enc_a_db), .enc_b_db(enc_b_db), .enc_btn_db(enc_btn_db),
    .enc_a_rise(enc_a_rise), .enc_btn_press(enc_btn_press),
    .step(step), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: state as it stands after each clock edge.
  bit m_s1[3], m_s2[3], m_db[3], m_prim[3], m_flip[3], m_live[3];
  int m_run[3], m_stab[3];

  function automatic int quad_pos(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    bit raw[3];
    bit e_rise, e_press, e_step, e_dir, e_err;
    raw[0] = enc_a; raw[1] = enc_b; raw[2] = enc_btn;
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_prim[i] = 0;
        m_flip[i] = 0; m_live[i] = 0; m_run[i] = 0; m_stab[i] = 0;
      end
    end else begin
      e_rise  = m_flip[0] && m_live[0] && m_db[0];
      e_press = m_flip[2] && m_live[2] && m_db[2];
      e_step = 0; e_dir = 0; e_err = 0;
`ifdef ENC_FULL_QUAD_EN
      if ((m_flip[0] || m_flip[1]) &&
          !((m_flip[0] && !m_live[0]) || (m_flip[1] && !m_live[1]))) begin
        if (m_flip[0] && m_flip[1]) e_err = 1;
        else begin
          int old_p, new_p;
          old_p = quad_pos(m_flip[0] ? !m_db[0] : m_db[0], m_flip[1] ? !m_db[1] : m_db[1]);
          new_p = quad_pos(m_db[0], m_db[1]);
          e_step = 1;
          e_dir  = (new_p == (old_p + 1) % 4);
        end
      end
`else
      e_step = e_rise;
      e_dir  = e_rise && m_db[1];
`endif
      if (e_rise || e_press || e_step || e_err)
        exp_q.push_back({cyc[26:0], e_rise, e_press, e_step, e_dir, e_err});
      for (int i = 0; i < 3; i++) begin
        m_flip[i] = 0; m_live[i] = 0;
        if (m_s2[i] == m_db[i]) begin
          m_run[i] = 0;
          if (!m_prim[i]) begin
            m_stab[i]++;
            if (m_stab[i] >= DB) m_prim[i] = 1;
          end
        end else begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_db[i] = m_s2[i]; m_run[i] = 0; m_flip[i] = 1;
            m_live[i] = m_prim[i]; m_prim[i] = 1;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
  end

  // Monitor: levels every cycle, pulses against the expected queue.
  int n_rise = 0, n_press = 0, n_step = 0, n_up = 0, n_err = 0;
  int last_rise_cyc = -1;

  always @(posedge clk) begin
    logic [W-1:0] act, exp;
    #1;
    check("a_db", enc_a_db, m_db[0]);
    check("b_db", enc_b_db, m_db[1]);
    check("btn_db", enc_btn_db, m_db[2]);
    while (exp_q.size() > 0 && exp_q[0][W-1:5] < cyc[26:0]) begin
      exp = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missed_pulse expected=%h at cycle %0d actual=absent", exp, exp[W-1:5]);
    end
    if (enc_a_rise || enc_btn_press || step || err) begin
      act = {cyc[26:0], enc_a_rise, enc_btn_press, step, step & dir, err};
      if (enc_a_rise) begin n_rise++; last_rise_cyc = cyc; end
      if (enc_btn_press) n_press++;
      if (step) begin n_step++; if (dir) n_up++; end
      if (err) n_err++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse actual=%h expected=none", act);
      end else begin
        exp = exp_q.pop_front();
        check("pulse_word", int'(act), int'(exp));
      end
    end
  end

  task automatic set_pins(input logic a, input logic b, input logic btn);
    @(negedge clk);
    enc_a = a; enc_b = b; enc_btn = btn;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_outputs_zero",
          int'({enc_a_db, enc_b_db, enc_btn_db, enc_a_rise, enc_btn_press, step, dir, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r0, p0, s0, u0, e0, t0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({enc_a_db, enc_b_db, enc_btn_db, enc_a_rise,
                                 enc_btn_press, step, dir, err}), 0);
    rst_n = 1'b1;
    idle(10);

    // Clean A rise with B high, then with B low.
    for (int pass = 0; pass < 2; pass++) begin
      set_pins(1'b0, pass == 0, 1'b0);
      idle(12);
      r0 = n_rise; s0 = n_step; u0 = n_up;
      @(negedge clk);
      enc_a = 1'b1;
      t0 = cyc + 1;
      idle(12);
      check("clean_rise_count", n_rise - r0, 1);
      check("clean_rise_cycle", last_rise_cyc, t0 + 7);
`ifndef ENC_FULL_QUAD_EN
      check("clean_step_count", n_step - s0, 1);
      check("clean_dir", n_up - u0, pass == 0 ? 1 : 0);
`endif
      set_pins(1'b0, enc_b, 1'b0);
      idle(12);
      check("fall_no_rise", n_rise - r0, 1);
    end

    // Bounce: 3 high, 1 low, 5 high -> one rise; then 2 high -> nothing.
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
    r0 = n_rise;
    set_pins(1'b1, 1'b0, 1'b0); idle(2);
    set_pins(1'b0, 1'b0, 1'b0);
    set_pins(1'b1, 1'b0, 1'b0); idle(4);
    set_pins(1'b0, 1'b0, 1'b0); idle(14);
    check("bounce_one_rise", n_rise - r0, 1);
    r0 = n_rise;
    set_pins(1'b1, 1'b0, 1'b0); idle(1);
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
    check("short_glitch_no_rise", n_rise - r0, 0);
    check("short_glitch_a_db", enc_a_db, 0);

    // Button held 10 cycles then released.
    p0 = n_press;
    set_pins(1'b0, 1'b0, 1'b1); idle(9);
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
    check("button_one_press", n_press - p0, 1);
    check("button_released", enc_btn_db, 0);

    // Reset with all pins high: first acceptance is silent.
    r0 = n_rise; p0 = n_press; s0 = n_step; e0 = n_err;
    @(negedge clk);
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1; enc_btn = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(15);
    check("primed_levels", int'({enc_a_db, enc_b_db, enc_btn_db}), 7);
    check("primed_no_pulses", (n_rise - r0) + (n_press - p0) + (n_step - s0) + (n_err - e0), 0);
    set_pins(1'b0, 1'b0, 1'b0); idle(15);

    // Reset mid-qualification of A.
    r0 = n_rise;
    set_pins(1'b1, 1'b0, 1'b0); idle(3);
    reset_pulse();
    idle(15);
    check("midqual_reset_no_rise", n_rise - r0, 0);
    set_pins(1'b0, 1'b0, 1'b0); idle(15);

`ifdef ENC_FULL_QUAD_EN
    s0 = n_step; u0 = n_up;
    set_pins(1'b1, 1'b0, 1'b0); idle(7);
    set_pins(1'b1, 1'b1, 1'b0); idle(7);
    set_pins(1'b0, 1'b1, 1'b0); idle(7);
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
    check("quad_up_steps", n_step - s0, 4);
    check("quad_up_dir", n_up - u0, 4);
    s0 = n_step; u0 = n_up;
    set_pins(1'b0, 1'b1, 1'b0); idle(7);
    set_pins(1'b1, 1'b1, 1'b0); idle(7);
    set_pins(1'b1, 1'b0, 1'b0); idle(7);
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
    check("quad_down_steps", n_step - s0, 4);
    check("quad_down_dir", n_up - u0, 0);
    s0 = n_step; e0 = n_err;
    set_pins(1'b1, 1'b1, 1'b0); idle(12);
    check("quad_err_count", n_err - e0, 1);
    check("quad_err_no_step", n_step - s0, 0);
    set_pins(1'b0, 1'b0, 1'b0); idle(12);
`endif

    // Randomized segments with occasional resets.
    for (int k = 0; k < 300; k++) begin
      set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) reset_pulse();
    end
    set_pins(1'b0, 1'b0, 1'b0);
    idle(20);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
